instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: DATA_WIDTH, 32, instruction word width in bits; a multiple of 8.
REQ-002 Parameter: ADDRESS_WIDTH, 8, word-index width of the target instruction memory.
REQ-003 Parameter: BASE_ADDR, 0, word index of the first written instruction.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-007 Port: num_words  input  ADDRESS_WIDTH  word count; sampled in the cycle start is honoured.
REQ-008 Port: abort  input  1  cancels any load in progress.
REQ-009 Port: byte_valid  input  1  byte_data carries a valid byte.
REQ-010 Port: byte_data  input  8  instruction byte stream, little-endian within each word.
REQ-011 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-012 Port: we  output  1  instruction-memory write enable.
REQ-013 Port: waddr  output  ADDRESS_WIDTH  instruction-memory write address, word-indexed.
REQ-014 Port: wdata  output  DATA_WIDTH  instruction-memory write data.
REQ-015 Port: busy  output  1  high in LOAD and WRITE.
REQ-016 Port: done  output  1  one-cycle pulse when all num_words words are written.

Function
REQ-017 States SHALL be IDLE, LOAD, WRITE and DONE.
REQ-018 IDLE with start=1 SHALL latch num_words, clear the word and byte counters, then go to LOAD; if num_words=0 it SHALL go to DONE instead.
REQ-019 byte_ready SHALL be 1 only in LOAD with abort=0; a byte is accepted only when byte_valid=1 and byte_ready=1.
REQ-020 The k-th accepted byte of a word (k=0..DATA_WIDTH/8-1) SHALL be stored at bits [8k+7:8k] of the assembly register.
REQ-021 Acceptance of the last byte of a word SHALL cause a transition to WRITE on the next edge.
REQ-022 WRITE SHALL last exactly one cycle with we=1, waddr=BASE_ADDR+word_count (modulo 2**ADDRESS_WIDTH) and wdata equal to the assembled word.
REQ-023 After WRITE, word_count SHALL increment; the block SHALL go to DONE if word_count equals the latched num_words, otherwise back to LOAD.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-025 Outside WRITE, we SHALL be 0 and waddr and wdata SHALL hold their last driven values.
REQ-026 abort=1 in any state SHALL force IDLE on the next edge, clear the counters and suppress we in that cycle; a partial word SHALL never be written.
REQ-027 start in LOAD, WRITE or DONE SHALL be ignored; abort takes priority over start in IDLE.
REQ-028 Gaps in byte_valid SHALL stall LOAD indefinitely without losing already-accepted bytes.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, with byte_ready=0, we=0, waddr=0, wdata=0, busy=0 and done=0, and SHALL clear all counters and the assembly register.
REQ-030 Reset asserted mid-load SHALL discard the partial word; no write SHALL occur until a new start.

Structure
REQ-031 The state enum and the BYTES_PER_WORD constant (DATA_WIDTH/8) SHALL live in the shared package instr_loader_pkg.
REQ-032 Byte assembly SHALL be a sub-module, byte_packer (shift-in register plus byte counter), instantiated once.
REQ-033 The write port SHALL match the instruction memory's word-indexed addressing so that readback at address A returns the word written at A.

Verification
REQ-034 Reset, then start with num_words=2 and bytes 13,00,50,00,B3,00,00,00 on consecutive cycles -> we pulses at waddr=0 with wdata=00500013, then at waddr=1 with wdata=000000B3; done pulses one cycle after the second write.
REQ-035 start with num_words=0 -> done pulses on the next cycle; we is never asserted.
REQ-036 Same stream as REQ-034 with byte_valid low on alternate cycles -> identical writes; byte_ready is 0 during each WRITE cycle.
REQ-037 abort after 3 bytes of the first word -> no we, return to IDLE; a new start with num_words=1 writes only its own fresh 4 bytes at waddr=0.
REQ-038 rst_n pulsed low mid-word -> all outputs are 0 within the same cycle; no subsequent write occurs without a new start.
REQ-039 BASE_ADDR=254 with ADDRESS_WIDTH=8 and num_words=3 -> writes go to waddr 254, 255, then 0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared state encoding and word geometry for instr_loader
package instr_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word assembly register with byte counter
module byte_packer #(
  parameter int unsigned BPW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         byte_data,
  output logic [8*BPW-1:0]   word,
  output logic               word_complete
);

  localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0]  cnt_q;
  logic [8*BPW-1:0]  word_q;
  logic              last_byte;

  assign last_byte     = (cnt_q == CNT_W'(BPW - 1));
  assign word_complete = accept && last_byte;
  assign word          = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (accept) begin
      word_q[cnt_q*8 +: 8] <= byte_data;
      cnt_q                <= last_byte ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loads a byte stream into word-indexed instruction memory
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] num_words,
  input  logic                     abort,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned BPW = bytes_per_word(DATA_WIDTH);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] num_words_q;
  logic [ADDRESS_WIDTH-1:0] word_count_q;
  logic [ADDRESS_WIDTH-1:0] word_count_inc;
  logic [ADDRESS_WIDTH-1:0] word_addr;
  logic [ADDRESS_WIDTH-1:0] waddr_hold_q;
  logic [DATA_WIDTH-1:0]    wdata_hold_q;
  logic [DATA_WIDTH-1:0]    packed_word;
  logic                     word_complete;
  logic                     accept;
  logic                     start_ok;
  logic                     packer_clear;

  assign start_ok       = (state_q == ST_IDLE) && start && !abort;
  assign packer_clear   = start_ok || abort;
  assign accept         = byte_valid && byte_ready;
  assign word_count_inc = word_count_q + ADDRESS_WIDTH'(1);
  assign word_addr      = ADDRESS_WIDTH'(BASE_ADDR) + word_count_q;

  byte_packer #(
    .BPW (BPW)
  ) u_byte_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (packer_clear),
    .accept        (accept),
    .byte_data     (byte_data),
    .word          (packed_word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_words == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:  if (word_complete) state_d = ST_WRITE;
      ST_WRITE: state_d = (word_count_inc == num_words_q) ? ST_DONE : ST_LOAD;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Write port is live only in WRITE; elsewhere it replays the last written address/data.
  always_comb begin
    byte_ready = (state_q == ST_LOAD) && !abort;
    we         = (state_q == ST_WRITE) && !abort;
    busy       = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    done       = (state_q == ST_DONE);
    waddr      = (state_q == ST_WRITE) ? word_addr : waddr_hold_q;
    wdata      = (state_q == ST_WRITE) ? packed_word : wdata_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_words_q  <= '0;
      word_count_q <= '0;
      waddr_hold_q <= '0;
      wdata_hold_q <= '0;
    end else begin
      if (abort) begin
        word_count_q <= '0;
      end else if (start_ok) begin
        num_words_q  <= num_words;
        word_count_q <= '0;
      end else if (state_q == ST_WRITE) begin
        word_count_q <= word_count_inc;
      end
      if (state_q == ST_WRITE) begin
        waddr_hold_q <= word_addr;
        wdata_hold_q <= packed_word;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed and randomized checks of instr_loader against a stream model
module tb_instr_loader;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_words = '0;
  logic          abort = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;

  logic          byte_ready_a, we_a, busy_a, done_a;
  logic [AW-1:0] waddr_a;
  logic [DW-1:0] wdata_a;
  logic          byte_ready_b, we_b, busy_b, done_b;
  logic [AW-1:0] waddr_b;
  logic [DW-1:0] wdata_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  instr_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_a),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .busy(busy_a), .done(done_a)
  );

  instr_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BASE_ADDR(254)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_b),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int unsigned wa_addr[$];
  int unsigned wa_data[$];
  int          wa_cyc[$];
  int unsigned wb_addr[$];
  int unsigned wb_data[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [7:0]  stream[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we_a) begin
      wa_addr.push_back(32'(waddr_a));
      wa_data.push_back(wdata_a);
      wa_cyc.push_back(cyc);
      chk("ready_low_in_write", 64'(byte_ready_a), 64'd0);
    end
    if (we_b) begin
      wb_addr.push_back(32'(waddr_b));
      wb_data.push_back(wdata_b);
    end
    if (done_a) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] model_word(input int idx);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w = w | (32'(stream[idx*4 + k]) << (8*k));
    return w;
  endfunction

  task automatic clear_log();
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    wb_addr.delete(); wb_data.delete();
  endtask

  // gaps: 0 = always valid, 1 = alternate valid, 2 = random valid
  task automatic feed(input int n, input int gaps);
    logic v;
    logic acc;
    int guard;
    v = 1'b0;
    start = 1'b1; num_words = AW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < stream.size(); i++) begin
      acc = 1'b0; guard = 0;
      while (!acc && guard < 200) begin
        if (gaps == 1) v = ~v;
        else if (gaps == 2) v = 1'($urandom_range(0, 1));
        else v = 1'b1;
        byte_valid = v; byte_data = stream[i];
        @(negedge clk);
        acc = byte_valid && byte_ready_a;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) chk("byte_accept_timeout", 64'(acc), 64'd1);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int guard;
    guard = 0;
    while (done_cnt == prev && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("done_seen", 64'(done_cnt > prev), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_against_model(input string tag, input int n);
    chk({tag, "_count_a"}, 64'(wa_addr.size()), 64'(n));
    chk({tag, "_count_b"}, 64'(wb_addr.size()), 64'(n));
    if (wa_addr.size() == n && wb_addr.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({tag, "_addr_a"}, 64'(wa_addr[i]), 64'(i % 256));
        chk({tag, "_data_a"}, 64'(wa_data[i]), 64'(model_word(i)));
        chk({tag, "_addr_b"}, 64'(wb_addr[i]), 64'((254 + i) % 256));
        chk({tag, "_data_b"}, 64'(wb_data[i]), 64'(model_word(i)));
      end
    end
  endtask

  initial begin
    int prev;
    int n;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_byte_ready", 64'(byte_ready_a), 64'd0);
    chk("rst_we", 64'(we_a), 64'd0);
    chk("rst_waddr", 64'(waddr_a), 64'd0);
    chk("rst_wdata", 64'(wdata_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // two-word directed load
    stream = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
    clear_log(); prev = done_cnt;
    feed(2, 0);
    wait_done(prev);
    chk("dir_count", 64'(wa_addr.size()), 64'd2);
    if (wa_addr.size() == 2) begin
      chk("dir_addr0", 64'(wa_addr[0]), 64'd0);
      chk("dir_data0", 64'(wa_data[0]), 64'h0050_0013);
      chk("dir_addr1", 64'(wa_addr[1]), 64'd1);
      chk("dir_data1", 64'(wa_data[1]), 64'h0000_00B3);
      chk("dir_done_after_write", 64'(done_cyc), 64'(wa_cyc[1] + 1));
    end

    // zero-word load
    clear_log(); prev = done_cnt;
    start = 1'b1; num_words = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", 64'(done_a), 64'd1);
    chk("zero_busy", 64'(busy_a), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_no_write", 64'(wa_addr.size()), 64'd0);

    // alternating byte_valid gaps
    clear_log(); prev = done_cnt;
    feed(2, 1);
    wait_done(prev);
    chk("gap_count", 64'(wa_addr.size()), 64'd2);
    if (wa_addr.size() == 2) begin
      chk("gap_data0", 64'(wa_data[0]), 64'h0050_0013);
      chk("gap_data1", 64'(wa_data[1]), 64'h0000_00B3);
      chk("gap_addr1", 64'(wa_addr[1]), 64'd1);
    end

    // abort after three bytes, then a fresh one-word load
    clear_log();
    stream = '{8'($urandom), 8'($urandom), 8'($urandom)};
    feed(1, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_no_write", 64'(wa_addr.size() + wb_addr.size()), 64'd0);
    @(posedge clk); #1;
    stream = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    prev = done_cnt;
    feed(1, 0);
    wait_done(prev);
    check_against_model("abort_reload", 1);

    // reset pulse mid-word
    clear_log();
    stream = '{8'hAA, 8'h55};
    feed(1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_byte_ready", 64'(byte_ready_a), 64'd0);
    chk("midrst_we", 64'(we_a), 64'd0);
    chk("midrst_waddr", 64'(waddr_a), 64'd0);
    chk("midrst_wdata", 64'(wdata_a), 64'd0);
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_done", 64'(done_a), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1; byte_data = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("midrst_no_write", 64'(wa_addr.size() + wb_addr.size()), 64'd0);
    chk("midrst_idle", 64'(busy_a), 64'd0);

    // base address wrap on the BASE_ADDR=254 instance
    clear_log();
    stream.delete();
    for (int i = 0; i < 12; i++) stream.push_back(8'($urandom));
    prev = done_cnt;
    feed(3, 0);
    wait_done(prev);
    check_against_model("wrap", 3);

    // randomized loads
    for (int t = 0; t < 6; t++) begin
      clear_log();
      stream.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom));
      prev = done_cnt;
      feed(n, 2);
      wait_done(prev);
      check_against_model("rand", n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
